// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM state and op classification for mdu_core
// MDU_MACC_EN makes MADD/MADDU/MSUB/MSUBU legal multiply-class ops.
package mdu_pkg;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // How the pending pair is applied to HI/LO at commit.
   typedef enum logic [1:0] {
      CM_LOAD = 2'd0,
      CM_ADD  = 2'd1,
      CM_SUB  = 2'd2,
      CM_KEEP = 2'd3
   } commit_e;

   function automatic logic is_macc(input logic [3:0] op);
`ifdef MDU_MACC_EN
      return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
      return (op == 4'hF) && (op != 4'hF);
`endif
   endfunction

   function automatic logic is_mul(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || is_macc(op);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - combinational signed/unsigned divider
// Signed results truncate toward zero; remainder follows the dividend's sign.
module mdu_divider #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sgn,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             div_zero
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] mag_q;
   logic [WIDTH-1:0] mag_r;

   always_comb begin
      neg_a    = sgn & a[WIDTH-1];
      neg_b    = sgn & b[WIDTH-1];
      mag_a    = neg_a ? -a : a;
      mag_b    = neg_b ? -b : b;
      mag_q    = '0;
      mag_r    = '0;
      quo      = '0;
      rem      = '0;
      div_zero = (b == '0);
      if (!div_zero) begin
         mag_q = mag_a / mag_b;
         mag_r = mag_a % mag_b;
         // MIN / -1 overflows; its architected result is MIN rem 0.
         if (sgn && (a == MIN_VAL) && (b == ALL_ONE)) begin
            quo = MIN_VAL;
            rem = '0;
         end else begin
            quo = (neg_a ^ neg_b) ? -mag_q : mag_q;
            rem = neg_a ? -mag_r : mag_r;
         end
      end
   end

endmodule

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - multi-cycle multiply/divide unit owning HI/LO
// MDU_MACC_EN enables multiply-accumulate ops applied to HI/LO at commit.
module mdu_core
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Flush,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   state_e             state;
   state_e             state_next;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_next;
   logic               accept;
   logic               commit;
   logic               wr_hi;
   logic               wr_lo;
   logic               last;

   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   pend_hi;
   logic [WIDTH-1:0]   pend_lo;
   commit_e            pend_kind;
   logic               pend_dz;
   logic               done_q;
   logic               dz_q;

   logic               mul_sgn;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   new_hi;
   logic [WIDTH-1:0]   new_lo;
   commit_e            new_kind;
   logic               new_dz;

   mdu_divider #(.WIDTH(WIDTH)) u_div (
      .a        (A),
      .b        (B),
      .sgn      (Op == OP_DIV),
      .quo      (div_quo),
      .rem      (div_rem),
      .div_zero (div_zero)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= state_next;
   end

   // The commit edge doubles as an idle edge so back-to-back starts are taken.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      commit     = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      last       = (state == RUN) && (cnt == CW'(1));
      case (state)
         IDLE: ;
         RUN: begin
            if (Flush) begin
               state_next = IDLE;
            end else if (last) begin
               commit     = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      if (Start && !Flush && ((state == IDLE) || last)) begin
         if (is_mul(Op)) begin
            accept     = 1'b1;
            state_next = RUN;
            cnt_next   = CW'(MULT_CYCLES);
         end else if (is_div(Op)) begin
            accept     = 1'b1;
            state_next = RUN;
            cnt_next   = CW'(DIV_CYCLES);
         end else if (Op == OP_MTHI) begin
            wr_hi = 1'b1;
         end else if (Op == OP_MTLO) begin
            wr_lo = 1'b1;
         end
      end
   end

   always_comb begin
      mul_sgn  = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);
      ext_a    = {{WIDTH{mul_sgn & A[WIDTH-1]}}, A};
      ext_b    = {{WIDTH{mul_sgn & B[WIDTH-1]}}, B};
      product  = ext_a * ext_b;
      new_hi   = product[2*WIDTH-1:WIDTH];
      new_lo   = product[WIDTH-1:0];
      new_kind = CM_LOAD;
      new_dz   = 1'b0;
      if (is_div(Op)) begin
         new_hi   = div_rem;
         new_lo   = div_quo;
         new_kind = div_zero ? CM_KEEP : CM_LOAD;
         new_dz   = div_zero;
      end else if ((Op == OP_MADD) || (Op == OP_MADDU)) begin
         new_kind = CM_ADD;
      end else if ((Op == OP_MSUB) || (Op == OP_MSUBU)) begin
         new_kind = CM_SUB;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_kind <= CM_LOAD;
         pend_dz   <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         done_q <= commit;
         dz_q   <= commit & pend_dz;
         if (commit) begin
            case (pend_kind)
               CM_LOAD: {hi_q, lo_q} <= {pend_hi, pend_lo};
               CM_ADD:  {hi_q, lo_q} <= {hi_q, lo_q} + {pend_hi, pend_lo};
               CM_SUB:  {hi_q, lo_q} <= {hi_q, lo_q} - {pend_hi, pend_lo};
               default: ;
            endcase
         end
         if (wr_hi) hi_q <= A;
         if (wr_lo) lo_q <= A;
         if (accept) begin
            pend_hi   <= new_hi;
            pend_lo   <= new_lo;
            pend_kind <= new_kind;
            pend_dz   <= new_dz;
         end
      end
   end

   assign Busy    = (state == RUN);
   assign Done    = done_q;
   assign DivZero = dz_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// tb/tb_mdu_core.sv - directed self-checking bench for mdu_core
// MDU_MACC_EN selects the accumulate or the illegal-op check.
module tb_mdu_core;
   import mdu_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  Op = 4'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Flush = 1'b0;
   logic        Busy;
   logic        Done;
   logic        DivZero;
   logic [31:0] HI;
   logic [31:0] LO;

   int pass_cnt = 0;
   int total    = 0;

   mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Flush   (Flush),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero),
      .HI      (HI),
      .LO      (LO)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      step();
      Start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] eh,
                         input logic [31:0] el, input logic ez);
      issue(op, a, b);
      for (int k = 1; k <= n; k++) begin
         check({tag, ".busy_done"}, {62'd0, Busy, Done}, 64'd2);
         step();
      end
      check({tag, ".busy_end"}, {63'd0, Busy}, 64'd0);
      check({tag, ".done"}, {63'd0, Done}, 64'd1);
      check({tag, ".divzero"}, {63'd0, DivZero}, {63'd0, ez});
      check({tag, ".hi"}, {32'd0, HI}, {32'd0, eh});
      check({tag, ".lo"}, {32'd0, LO}, {32'd0, el});
      step();
      check({tag, ".done_clr"}, {62'd0, Done, DivZero}, 64'd0);
   endtask

   initial begin
      #2;
      check("rst.hi", {32'd0, HI}, 64'd0);
      check("rst.lo", {32'd0, LO}, 64'd0);
      check("rst.flags", {61'd0, Busy, Done, DivZero}, 64'd0);
      Rst = 1'b1;
      step();

      run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
      run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);

      issue(OP_MTHI, 32'h11, 32'd0);
      check("mthi.hi", {32'd0, HI}, 64'h11);
      check("mthi.flags", {62'd0, Busy, Done}, 64'd0);
      issue(OP_MTLO, 32'h22, 32'd0);
      check("mtlo.lo", {32'd0, LO}, 64'h22);
      check("mtlo.hi", {32'd0, HI}, 64'h11);

      run_op("div0", OP_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b1);

      // Flush in busy cycle 3 with a competing Start.
      issue(OP_MULT, 32'd3, 32'd5);
      step();
      step();
      Flush = 1'b1;
      Start = 1'b1;
      Op    = OP_MULTU;
      A     = 32'd9;
      B     = 32'd9;
      step();
      Flush = 1'b0;
      Start = 1'b0;
      check("flush.busy", {63'd0, Busy}, 64'd0);
      for (int k = 0; k < 8; k++) begin
         check("flush.quiet", {62'd0, Busy, Done}, 64'd0);
         step();
      end
      check("flush.hi", {32'd0, HI}, 64'h11);
      check("flush.lo", {32'd0, LO}, 64'h22);

      // Back-to-back: new start on the commit edge.
      issue(OP_MULTU, 32'd6, 32'd7);
      for (int k = 1; k < 5; k++) step();
      Start = 1'b1;
      Op    = OP_DIVU;
      A     = 32'd9;
      B     = 32'd4;
      step();
      Start = 1'b0;
      check("b2b.done", {62'd0, Busy, Done}, 64'd3);
      check("b2b.mul_lo", {32'd0, LO}, 64'd42);
      check("b2b.mul_hi", {32'd0, HI}, 64'd0);
      for (int k = 1; k < 10; k++) step();
      check("b2b.div_busy", {62'd0, Busy, Done}, 64'd2);
      step();
      check("b2b.div_done", {62'd0, Busy, Done}, 64'd1);
      check("b2b.div_lo", {32'd0, LO}, 64'd2);
      check("b2b.div_hi", {32'd0, HI}, 64'd1);
      step();

      // Asynchronous reset in busy cycle 4 of a DIV.
      issue(OP_DIV, 32'd100, 32'd7);
      step();
      step();
      step();
      #2;
      Rst = 1'b0;
      #1;
      check("arst.hi", {32'd0, HI}, 64'd0);
      check("arst.lo", {32'd0, LO}, 64'd0);
      check("arst.flags", {61'd0, Busy, Done, DivZero}, 64'd0);
      #1;
      Rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         check("arst.idle", {61'd0, Busy, Done, DivZero}, 64'd0);
      end

      issue(OP_MTHI, 32'd0, 32'd0);
      issue(OP_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MACC_EN
      run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'd1, 32'd0, 1'b0);
`else
      issue(OP_MADD, 32'd1, 32'd1);
      for (int k = 0; k < 7; k++) begin
         check("illegal.quiet", {62'd0, Busy, Done}, 64'd0);
         step();
      end
      check("illegal.hi", {32'd0, HI}, 64'd0);
      check("illegal.lo", {32'd0, LO}, 64'hFFFFFFFF);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/mdu_core.md
# mdu_core

Parametrised multiply/divide unit owning the HI/LO architectural registers for the execute stage of the pipelined CPU. It accepts one operation per Start pulse and holds Busy for a configurable latency, which the stall unit uses to hold mult/div/mfhi/mflo instructions in decode. It commits the result to HI/LO atomically and supports pipeline flush of an in-flight operation. It replaces the fixed 32-bit, fixed-latency multiply/divide path.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 2.
- MULT_CYCLES, 5: Busy cycles for multiply-class ops; must be ≥ 1.
- DIV_CYCLES, 10: Busy cycles for divide-class ops; must be ≥ 1.

- Clk  in  1  clock; all state changes on its rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  request; samples Op/A/B this edge.
- Op  in  4  operation code (mdu_pkg).
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- Flush  in  1  abort the in-flight operation.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; HI/LO just committed.
- DivZero  out  1  valid with Done; last divide had B == 0.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. A down-counter of width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1 tracks remaining cycles.
- Start in IDLE, without Flush:
  - MULT/MULTU/DIV/DIVU: latch the result into pending {pHI, pLO}. Load the counter with the op latency and go to RUN.
  - MTHI/MTLO: write A to HI/LO at this edge. Stay in IDLE; no Busy, no Done.
  - Illegal Op: ignored entirely.
- Start while in RUN is ignored. The stall unit must prevent this.
- RUN: decrement the counter each cycle. At the edge where it reaches the last cycle: HI/LO ← pending, go to IDLE, Done = 1 for the following cycle.
- Flush in RUN: go to IDLE at this edge. HI/LO and pending are discarded, no Done. Flush has priority over a same-cycle Start; that Start is ignored.
- Multiply: {HI, LO} = A × B, 2·WIDTH-bit product. MULT is signed; MULTU is unsigned.
- Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV of MIN / −1 gives LO = MIN, HI = 0.
- Division by zero: HI/LO unchanged at commit, Done pulses, DivZero = 1 for the Done cycle.
- DivZero is 0 whenever Done is 0.

## Timing
- Reset (Rst = 0, immediate, asynchronous): HI = 0, LO = 0, Busy = 0, Done = 0, DivZero = 0, state IDLE. This holds mid-operation; the pending result is lost.
- Start sampled at edge T0 → Busy = 1 during cycles T0+1 … T0+N (N = op latency).
- At edge T0+N: Busy = 0, HI/LO show the new values, Done = 1 for exactly one cycle.
- Back-to-back: a Start sampled at edge T0+N is accepted. The new Busy begins the same cycle Done is high.
- MTHI/MTLO: HI/LO visible in the cycle after the Start edge.
- Busy is a registered output; there is no combinational path from Start to Busy.

## Configuration
- MDU_MACC_EN defined: MADD/MADDU/MSUB/MSUBU are legal.
  - {HI, LO} ← {HI, LO} ± product, modulo 2^(2·WIDTH).
  - Latency is MULT_CYCLES.
  - The HI/LO value used is the one at commit time.
- MDU_MACC_EN undefined: these four codes are illegal and ignored (no Busy, no Done).

## Structure
- Package mdu_pkg holds:
  - Op codes: MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5, MADD = 6, MADDU = 7, MSUB = 8, MSUBU = 9; 10–15 illegal.
  - State enum (IDLE, RUN).
  - is_mul/is_div classification functions.
- Sub-module mdu_divider: combinational signed/unsigned divide with the MIN/−1 and zero-divisor cases, parametrised by WIDTH.

## Test plan
- MULT: A = 0xFFFFFFFF, B = 2 → Busy for 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, Done for 1 cycle. MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIVU 7/2 → after 10 Busy cycles, LO = 3, HI = 1. DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- HI = 0x11, LO = 0x22 (via MTHI/MTLO), then DIV by B = 0 → HI/LO unchanged; Done = 1 and DivZero = 1 in the same cycle.
- Flush in Busy cycle 3 of a MULT, with Start asserted in the same cycle → Busy = 0 next cycle, HI/LO unchanged, no Done, and the Start is not taken.
- Rst = 0 mid-DIV (Busy cycle 4) → HI, LO, Busy, Done, DivZero all 0 without waiting for a clock edge. After release, idle.
- With MDU_MACC_EN: HI = 0, LO = 0xFFFFFFFF, MADDU A = 1, B = 1 → HI = 1, LO = 0. Without the macro: Op = 6 → Busy stays 0 and HI/LO are unchanged.
